// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller for SLL/SRL/SRA (and their
// variable forms). The operand shifts one bit per cycle while busy is high,
// so the hazard unit can stall the pipeline until done pulses.
//
// Build option: define FAST_SHIFT_EN to add a 4-bit step. With it, the SHIFT
// state moves 4 bits per cycle while at least 4 remain. The final result is
// the same in both builds; only the latency changes.
//
// Handshake: start is a request that is only accepted while the block is idle
// (busy low). Accepting it captures op/shamt/data in the same edge. While busy
// is high, start is ignored and nothing is queued. done is high for exactly
// one cycle, and result is valid in that cycle. result then holds until the
// next accepted start.
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic [1:0]       op_reg;

   logic [WIDTH-1:0] acc_nxt;
   logic [SHW-1:0]   cnt_nxt;

   // One shift step: 4 bits when the fast path is built and at least 4
   // remain, otherwise 1 bit. cnt is only decremented when nonzero.
   always_comb begin
      acc_nxt = acc;
      cnt_nxt = cnt;
`ifdef FAST_SHIFT_EN
      if (cnt >= SHW'(4)) begin
         case (op_reg)
            OP_SLL:  acc_nxt = acc << 4;
            OP_SRL:  acc_nxt = acc >> 4;
            OP_SRA:  acc_nxt = {{4{acc[WIDTH-1]}}, acc[WIDTH-1:4]};
            default: acc_nxt = acc;
         endcase
         cnt_nxt = cnt - SHW'(4);
      end else begin
`else
      begin
`endif
         case (op_reg)
            OP_SLL:  acc_nxt = acc << 1;
            OP_SRL:  acc_nxt = acc >> 1;
            OP_SRA:  acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: acc_nxt = acc;
         endcase
         if (cnt != '0) begin
            cnt_nxt = cnt - SHW'(1);
         end
      end
   end

   // Control FSM and datapath registers. A reset in the middle of a shift
   // aborts it, and no done is issued for the aborted operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         acc    <= '0;
         cnt    <= '0;
         op_reg <= OP_SLL;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc    <= data;
                  cnt    <= shamt;
                  op_reg <= op;
                  if ((shamt == '0) || (op == OP_RSV)) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               acc <= acc_nxt;
               cnt <= cnt_nxt;
               if (cnt_nxt == '0) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Status outputs are decoded from registered state only, so there is no
   // combinational path from start.
   assign busy      = (state == S_SHIFT) || (state == S_DONE);
   assign done      = (state == S_DONE);
   assign result    = acc;
   assign state_dbg = state;

endmodule
